cnn_countdown_seq: RTL and testbench
====================================

// Module: cnn_countdown_seq
// PURPOSE
//   Beat sequencer for CNN layer loops: loads a beat total, then counts down one per
//   accepted output beat on a valid/ready handshake. Each beat carries a (row, col)
//   index pair for a feature map of programmable row length.
//   Flags the final beat, then pulses done. The up-counting loop counter is the other
//   end: it counts beats in; this block schedules and drains them.
// PARAMETERS
//   CNT_W  16  width of total/remain/row_idx
//   COL_W  8   width of row_len/col_idx
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous reset, active-low (all state cleared when rst==0)
//   start      in   1      load total/row_len and begin a run (honoured in IDLE only)
//   total      in   CNT_W  number of beats to issue; 0 = empty run
//   row_len    in   COL_W  beats per row; 0 = 2**COL_W
//   hold       in   1      freeze sequencer, suppress out_valid
//   abort      in   1      cancel run, return to IDLE, no done
//   out_valid  out  1      beat available
//   out_ready  in   1      consumer accepts beat
//   remain     out  CNT_W  beats still to issue (includes current beat)
//   col_idx    out  COL_W  column index of current beat
//   row_idx    out  CNT_W  row index of current beat
//   last       out  1      current beat is the final one (remain==1, in RUN)
//   busy       out  1      state != IDLE
//   done       out  1      one-cycle pulse after final beat accepted
// BEHAVIOUR
//   Reset (rst==0 at edge): state=IDLE, remain=0, col_idx=0, row_idx=0. Outputs
//     out_valid=0, last=0, busy=0, done=0. Overrides every other input, any state.
//   FSM states: IDLE, RUN, DONE. Priority each edge: rst > abort > start/beat logic.
//   IDLE: start&&total!=0 -> RUN; remain=total, col_idx=0, row_idx=0, row_len latched.
//         start&&total==0 -> DONE (no beat ever issued).
//   RUN:  out_valid = (state==RUN) && !hold (combinational from regs + hold).
//         beat = out_valid && out_ready. On beat: remain-=1.
//         Column step on beat: if col_idx==latched row_len-1 (row_len 0: col 2**COL_W-1),
//         col_idx=0 and row_idx+=1 (mod 2**CNT_W); else col_idx+=1.
//         Beat with remain==1 -> DONE. No beat -> all regs hold.
//         remain/col_idx/row_idx stable while out_valid&&!out_ready.
//         start ignored in RUN; total/row_len changes ignored after load.
//   hold: in RUN, forces out_valid=0, no beat, state frozen. Only legal way to drop
//     out_valid before acceptance. Hold in IDLE/DONE has no effect.
//   DONE: done=1 for exactly this cycle, busy=1, out_valid=0; -> IDLE next edge.
//     start in DONE ignored.
//   abort: any state -> IDLE next edge, remain=0, col/row=0, no done pulse.
//     abort+start same cycle in IDLE: abort wins, stays IDLE.
//     abort in DONE: done still shows this cycle (combinational from state), -> IDLE.
//   Latency: start accepted at edge N -> out_valid at cycle after N (1 cycle).
//     Final beat at edge M -> done high cycle after M. Back-to-back: start may be
//     accepted the cycle after done (IDLE).
//   Arithmetic: all counters unsigned, wrap silently. remain never decrements below 1
//     in RUN.
// TESTING
//   1 total=5,row_len=2,out_ready=1: start -> 5 consecutive beats (r,c)=(0,0),(0,1),
//     (1,0),(1,1),(2,0); last only on 5th, remain 5..1. done 1 cycle later, then IDLE.
//   2 total=4, out_ready pattern 1,0,0,1,0,1,1: exactly 4 beats.
//     remain/col/row unchanged on ready=0 cycles.
//   3 total=6: hold=1 for 3 cycles after 2nd beat -> out_valid=0, remain stays 4.
//     Resume yields remaining 4 beats, done once.
//   4 abort at remain=7 in RUN -> IDLE next cycle, busy=0, done never pulses.
//     abort+start same cycle in IDLE -> stays IDLE.
//   5 start with total=0 -> done at next cycle, out_valid never high.
//     Start during RUN is ignored.
//   6 total=300,row_len=0: col 255->0 with row 0->1 at beat 256.
//     rst=0 mid-run -> all outputs at reset values next edge.

Source files
------------

// File: rtl/cnn_countdown_seq.sv
// Beat sequencer for CNN layer loops: loads a beat total and drains it one beat per accepted
// valid/ready handshake, tagging each beat with a (row, col) index and pulsing done at the end.
module cnn_countdown_seq #(
  parameter int unsigned CntW = 16,
  parameter int unsigned ColW = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [CntW-1:0] total_i,
  input  logic [ColW-1:0] row_len_i,
  input  logic            hold_i,
  input  logic            abort_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [CntW-1:0] remain_o,
  output logic [ColW-1:0] col_idx_o,
  output logic [CntW-1:0] row_idx_o,
  output logic            last_o,
  output logic            busy_o,
  output logic            done_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] remain_q;
  logic [CntW-1:0] row_q;
  logic [ColW-1:0] col_q;
  logic [ColW-1:0] row_len_q;

  logic            beat;
  logic [ColW-1:0] col_inc;
  logic            col_wrap;

  assign out_valid_o = (state_q == StRun) && !hold_i;
  assign beat        = out_valid_o && out_ready_i;

  // A latched row_len of 0 means 2**ColW columns: col+1 wraps to 0 and matches it.
  assign col_inc  = col_q + ColW'(1);
  assign col_wrap = (col_inc == row_len_q);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      remain_q  <= '0;
      col_q     <= '0;
      row_q     <= '0;
      row_len_q <= '0;
    end else if (abort_i) begin
      state_q  <= StIdle;
      remain_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            remain_q  <= total_i;
            col_q     <= '0;
            row_q     <= '0;
            row_len_q <= row_len_i;
            state_q   <= (total_i != '0) ? StRun : StDone;
          end
        end
        StRun: begin
          if (beat) begin
            remain_q <= remain_q - CntW'(1);
            if (col_wrap) begin
              col_q <= '0;
              row_q <= row_q + CntW'(1);
            end else begin
              col_q <= col_inc;
            end
            if (remain_q == CntW'(1)) begin
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign remain_o  = remain_q;
  assign col_idx_o = col_q;
  assign row_idx_o = row_q;
  assign last_o    = (state_q == StRun) && (remain_q == CntW'(1));
  assign busy_o    = (state_q != StIdle);
  assign done_o    = (state_q == StDone);

endmodule

// File: tb/tb_cnn_countdown_seq.sv
// Scoreboard bench for cnn_countdown_seq: a job model pushes the expected beat list and done
// token per accepted start; a negedge monitor pops and compares every accepted beat.
module tb_cnn_countdown_seq;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] total_i = '0;
  logic [7:0]  row_len_i = '0;
  logic        hold_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [15:0] remain_o;
  logic [7:0]  col_idx_o;
  logic [15:0] row_idx_o;
  logic        last_o;
  logic        busy_o;
  logic        done_o;

  cnn_countdown_seq dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .total_i     (total_i),
    .row_len_i   (row_len_i),
    .hold_i      (hold_i),
    .abort_i     (abort_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .remain_o    (remain_o),
    .col_idx_o   (col_idx_o),
    .row_idx_o   (row_idx_o),
    .last_o      (last_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int unsigned remain;
    int unsigned col;
    int unsigned row;
    bit          last;
  } beat_t;

  beat_t beat_q[$];
  int    done_pend = 0;
  int    n_chk = 0;
  int    n_pass = 0;

  task automatic chk_eq(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Expected beat list for one job straight from the index arithmetic.
  task automatic model_push(input int unsigned tot, input int unsigned rl);
    int unsigned rle;
    beat_t b;
    rle = (rl == 0) ? 256 : rl;
    for (int unsigned i = 0; i < tot; i++) begin
      b.remain = tot - i;
      b.col    = i % rle;
      b.row    = (i / rle) % 65536;
      b.last   = (i == tot - 1);
      beat_q.push_back(b);
    end
    done_pend++;
  endtask

  task automatic model_flush();
    beat_q.delete();
    done_pend = 0;
  endtask

  // Monitor: compares accepted beats, done pulses and stall stability.
  logic        prev_stall = 1'b0;
  logic        prev_skip = 1'b1;
  logic [15:0] prev_remain = '0;
  logic [7:0]  prev_col = '0;
  logic [15:0] prev_row = '0;

  always @(negedge clk_i) begin
    beat_t e;
    if (rst_ni) begin
      if (out_valid_o) chk_eq("valid_while_hold", hold_i, 0);
      if (out_valid_o && out_ready_i) begin
        if (beat_q.size() == 0) begin
          chk_eq("unexpected_beat", 1, 0);
        end else begin
          e = beat_q.pop_front();
          chk_eq("beat_remain", remain_o, e.remain);
          chk_eq("beat_col", col_idx_o, e.col);
          chk_eq("beat_row", row_idx_o, e.row);
          chk_eq("beat_last", last_o, e.last);
        end
      end
      if (prev_stall && !prev_skip) begin
        chk_eq("stall_remain", remain_o, prev_remain);
        chk_eq("stall_col", col_idx_o, prev_col);
        chk_eq("stall_row", row_idx_o, prev_row);
      end
      if (done_o) begin
        if (done_pend == 0) begin
          chk_eq("unexpected_done", 1, 0);
        end else begin
          done_pend--;
          chk_eq("done_beats_left", beat_q.size(), 0);
          chk_eq("done_valid", out_valid_o, 0);
        end
      end
    end
    prev_stall  <= rst_ni && out_valid_o && !out_ready_i;
    prev_skip   <= abort_i || !rst_ni;
    prev_remain <= remain_o;
    prev_col    <= col_idx_o;
    prev_row    <= row_idx_o;
  end

  // Called just after a rising edge; returns at the negedge of the first cycle after load.
  task automatic start_job(input int unsigned tot, input int unsigned rl, input bit rdy);
    start_i   = 1'b1;
    total_i   = tot[15:0];
    row_len_i = rl[7:0];
    hold_i    = 1'b0;
    abort_i   = 1'b0;
    model_push(tot, rl);
    @(posedge clk_i);
    #1;
    start_i     = 1'b0;
    out_ready_i = rdy;
    @(negedge clk_i);
    if (tot != 0) begin
      chk_eq("load_busy", busy_o, 1);
      chk_eq("load_remain", remain_o, tot);
      chk_eq("load_valid", out_valid_o, 1);
    end else begin
      chk_eq("empty_done", done_o, 1);
      chk_eq("empty_busy", busy_o, 1);
      chk_eq("empty_valid", out_valid_o, 0);
    end
  endtask

  // Runs until the model has nothing outstanding; exits just after a rising edge.
  task automatic drain(input bit rnd, input bit stray);
    int cyc;
    cyc = 0;
    forever begin
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      if (beat_q.size() == 0 && done_pend == 0) break;
      if (cyc++ > 5000) begin
        chk_eq("drain_timeout", cyc, 0);
        break;
      end
      if (rnd) begin
        out_ready_i = ($urandom_range(0, 99) < 70);
        hold_i      = ($urandom_range(0, 99) < 12);
      end else begin
        out_ready_i = 1'b1;
        hold_i      = 1'b0;
      end
      if (stray && beat_q.size() > 0 && $urandom_range(0, 9) == 0) begin
        start_i   = 1'b1;
        total_i   = 16'($urandom_range(1, 100));
        row_len_i = 8'($urandom);
      end
    end
    hold_i = 1'b0;
  endtask

  initial begin
    int pat[7];
    pat = '{1, 0, 0, 1, 0, 1, 1};

    // Reset values
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk_eq("rst_valid", out_valid_o, 0);
    chk_eq("rst_busy", busy_o, 0);
    chk_eq("rst_done", done_o, 0);
    chk_eq("rst_last", last_o, 0);
    chk_eq("rst_remain", remain_o, 0);
    chk_eq("rst_col", col_idx_o, 0);
    chk_eq("rst_row", row_idx_o, 0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Five back-to-back beats, done one cycle after the last
    start_job(5, 2, 1'b1);
    repeat (4) begin
      @(negedge clk_i);
      chk_eq("t1_valid", out_valid_o, 1);
    end
    @(negedge clk_i);
    chk_eq("t1_done", done_o, 1);
    @(negedge clk_i);
    chk_eq("t1_idle", busy_o, 0);
    @(posedge clk_i);
    #1;

    // Ready pattern with stalls
    start_job(4, 3, 1'b1);
    for (int k = 1; k < 7; k++) begin
      @(posedge clk_i);
      #1 out_ready_i = pat[k][0];
    end
    drain(1'b0, 1'b0);

    // Hold after the second beat
    start_job(6, 4, 1'b1);
    @(posedge clk_i);
    #1;
    repeat (3) begin
      @(posedge clk_i);
      #1 hold_i = 1'b1;
      @(negedge clk_i);
      chk_eq("hold_valid", out_valid_o, 0);
      chk_eq("hold_remain", remain_o, 4);
    end
    drain(1'b0, 1'b0);

    // Abort at remain=7, then abort+start in IDLE
    start_job(10, 3, 1'b1);
    repeat (2) begin
      @(posedge clk_i);
      #1;
    end
    @(posedge clk_i);
    #1;
    out_ready_i = 1'b0;
    abort_i     = 1'b1;
    @(negedge clk_i);
    chk_eq("abort_pre_remain", remain_o, 7);
    @(posedge clk_i);
    #1 abort_i = 1'b0;
    model_flush();
    @(negedge clk_i);
    chk_eq("abort_busy", busy_o, 0);
    chk_eq("abort_valid", out_valid_o, 0);
    chk_eq("abort_remain", remain_o, 0);
    chk_eq("abort_col", col_idx_o, 0);
    chk_eq("abort_row", row_idx_o, 0);
    @(posedge clk_i);
    #1;
    start_i = 1'b1;
    total_i = 16'd5;
    abort_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    abort_i = 1'b0;
    @(negedge clk_i);
    chk_eq("abort_start_busy", busy_o, 0);
    chk_eq("abort_start_done", done_o, 0);
    @(posedge clk_i);
    #1;

    // Empty run, then random jobs with stray starts during RUN
    start_job(0, 5, 1'b1);
    drain(1'b1, 1'b0);
    for (int j = 0; j < 12; j++) begin
      int unsigned tot;
      tot = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
      start_job(tot, $urandom_range(0, 7), 1'($urandom));
      drain(1'b1, 1'b1);
    end

    // Full 256-column rows
    start_job(300, 0, 1'b1);
    drain(1'b1, 1'b0);

    // Reset mid-run
    start_job(50, 4, 1'b1);
    repeat (10) begin
      @(posedge clk_i);
      #1;
    end
    out_ready_i = 1'b0;
    rst_ni      = 1'b0;
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    model_flush();
    @(negedge clk_i);
    chk_eq("mrst_valid", out_valid_o, 0);
    chk_eq("mrst_busy", busy_o, 0);
    chk_eq("mrst_done", done_o, 0);
    chk_eq("mrst_last", last_o, 0);
    chk_eq("mrst_remain", remain_o, 0);
    chk_eq("mrst_col", col_idx_o, 0);
    chk_eq("mrst_row", row_idx_o, 0);

    // Back to normal operation after reset
    @(posedge clk_i);
    #1;
    start_job(7, 3, 1'b1);
    drain(1'b1, 1'b1);
    chk_eq("end_beats_left", beat_q.size(), 0);
    chk_eq("end_done_pending", done_pend, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
